luces_monitor: RTL and testbench
================================

Name: luces_monitor

Overview:
- Passive checker on the three-light sequencer outputs (LUZ_ROJA, LUZ_AMARILLA, LUZ_VERDE). It watches them cycle by cycle and reconstructs the sequencer's mode and run length.
- Flags any departure from the legal sequence: red idle, then yellow for the slow run or green for the fast run, then all three lights on.
- Sits beside the sequencer in the testbench and in the top-level debug logic. Has no influence on the sequencer.

Parameters:
- CUENTA_LENTO, 21, exact number of cycles yellow-only must be held in a legal slow run.
- CUENTA_RAPIDO, 11, exact number of cycles green-only must be held in a legal fast run.
- CW, 6, width of the run-length counter. Must satisfy 2^CW-1 > CUENTA_LENTO.
- TOL, 1, allowed run-length deviation in cycles. Used only with the optional feature.

Ports:
- CLK  input  1  system clock, rising edge.
- RESET  input  1  asynchronous, active-high reset.
- LUZ_ROJA  input  1  observed red light.
- LUZ_AMARILLA  input  1  observed yellow light.
- LUZ_VERDE  input  1  observed green light.
- MODO  output  2  detected mode: 00 none, 01 lento, 10 rapido.
- ACTIVO  output  1  high while a run (yellow or green phase) is being tracked.
- DURACION  output  CW  run length captured at run end.
- DONE  output  1  one-cycle pulse when a legal run completes.
- ERROR  output  1  sticky error flag.
- ERR_CODE  output  3  first error cause: 0 none, 1 ILEGAL, 2 SALTO, 3 CORTO, 4 LARGO, 5 POST.

Behaviour:
- Clock and reset: one clock CLK. Reset RESET is asynchronous, active-high.
- Reset values: all outputs 0; state M_IDLE; counter 0.
- Outputs are registered. They reflect the pattern sampled at the same rising edge, i.e. they are valid the cycle after that pattern appears.
- Input decode P = {R,A,V}:
  - 100 = ROJO
  - 010 = AMAR
  - 001 = VERDE
  - 111 = TODAS
  - any other value (000, 011, 101, 110) = ILEGAL
- States: M_IDLE, M_LENTO, M_RAPIDO, M_FINAL, M_ERROR.
- M_IDLE:
  - ROJO: stay.
  - AMAR: go to M_LENTO; cnt=1; MODO=01; ACTIVO=1.
  - VERDE: go to M_RAPIDO; cnt=1; MODO=10; ACTIVO=1.
  - TODAS: error SALTO.
  - ILEGAL: error ILEGAL.
- M_LENTO (M_RAPIDO is identical with VERDE and CUENTA_RAPIDO):
  - AMAR with cnt < CUENTA_LENTO: cnt+1.
  - AMAR with cnt == CUENTA_LENTO: error LARGO, raised immediately without waiting for the run to end.
  - TODAS with cnt == CUENTA_LENTO: go to M_FINAL; DURACION=cnt; DONE=1 for one cycle; ACTIVO=0.
  - TODAS with cnt < CUENTA_LENTO: error CORTO; DURACION=cnt.
  - ROJO, the other run colour, or ILEGAL: error ILEGAL.
- M_FINAL:
  - TODAS: stay; MODO and DURACION hold.
  - Anything else: error POST.
- Error entry: go to M_ERROR; ERROR=1; ERR_CODE latched; ACTIVO=0; DONE never asserts. MODO holds its last value.
- M_ERROR is sticky until RESET. Later patterns are ignored, so only the first cause is reported.
- Counter: CW bits wide, saturating at 2^CW-1 and never wrapping. Overflow is unreachable given the LARGO check.
- Reset mid-run: RESET asserted asynchronously in any state returns immediately to the reset values. The first edge after RESET deasserts samples normally.
- DONE and ERROR are never both high in the same cycle.

Optional Feature:
- Macro: LUCES_TOLERANCIA_EN.
- Defined:
  - Run end is legal when |cnt - CUENTA_x| <= TOL.
  - LARGO fires when the run colour is still present at cnt == CUENTA_x + TOL.
  - CORTO fires when TODAS arrives with cnt < CUENTA_x - TOL.
- Undefined: exact match is required; TOL is ignored.

Test Plan:
- Legal slow run: RESET, ROJO x5, AMAR x21, TODAS x10 -> cycle after the first TODAS: DONE=1 for one cycle, MODO=01, DURACION=21, ERROR=0; MODO and DURACION hold afterwards.
- Legal fast run: ROJO x3, VERDE x11, TODAS -> DONE pulse, MODO=10, DURACION=11.
- Short fast run: VERDE x9, then TODAS -> ERROR=1, ERR_CODE=3, DURACION=9, no DONE. Also run VERDE x10 then TODAS with LUCES_TOLERANCIA_EN defined and TOL=1 -> DONE, DURACION=10.
- Long slow run: AMAR x22 -> ERROR=1 and ERR_CODE=4 one cycle after the 22nd AMAR sample.
- Illegal and ordering errors:
  - pattern 110 in IDLE -> ERR_CODE=1
  - TODAS directly from ROJO -> ERR_CODE=2
  - ROJO after FINAL -> ERR_CODE=5
  - follow each with 3 further distinct errors -> ERR_CODE unchanged
- Async reset mid-run: assert RESET between clock edges at AMAR x7 -> all outputs 0 before the next edge. Then a legal fast run -> DONE with DURACION=11.

Source files
------------

// File: rtl/luces_monitor.sv
// Purpose: passive checker for the red/yellow/green sequencer; rebuilds mode and run length and flags the first illegal step.
// Latency: registered outputs, valid one cycle after the sampled light pattern.
// Backpressure: none; observe-only, the sequencer is never stalled.
// Optional feature: define LUCES_TOLERANCIA_EN to accept run lengths within +/-TOL of the nominal count.
module luces_monitor #(
  parameter int CUENTA_LENTO  = 21,
  parameter int CUENTA_RAPIDO = 11,
  parameter int CW            = 6,
  parameter int TOL           = 1
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          LUZ_ROJA,
  input  logic          LUZ_AMARILLA,
  input  logic          LUZ_VERDE,
  output logic [1:0]    MODO,
  output logic          ACTIVO,
  output logic [CW-1:0] DURACION,
  output logic          DONE,
  output logic          ERROR,
  output logic [2:0]    ERR_CODE
);

`ifdef LUCES_TOLERANCIA_EN
  localparam int TOL_EFF = TOL;
`else
  // Exact run length required: the tolerance window collapses to zero.
  localparam int TOL_EFF = TOL * 0;
`endif

  localparam logic [CW-1:0] LENTO_LO  = CW'(CUENTA_LENTO - TOL_EFF);
  localparam logic [CW-1:0] LENTO_HI  = CW'(CUENTA_LENTO + TOL_EFF);
  localparam logic [CW-1:0] RAPIDO_LO = CW'(CUENTA_RAPIDO - TOL_EFF);
  localparam logic [CW-1:0] RAPIDO_HI = CW'(CUENTA_RAPIDO + TOL_EFF);

  localparam logic [2:0] E_ILEGAL = 3'd1;
  localparam logic [2:0] E_SALTO  = 3'd2;
  localparam logic [2:0] E_CORTO  = 3'd3;
  localparam logic [2:0] E_LARGO  = 3'd4;
  localparam logic [2:0] E_POST   = 3'd5;

  typedef enum logic [2:0] {M_IDLE, M_LENTO, M_RAPIDO, M_FINAL, M_ERROR} state_t;
  typedef enum logic [2:0] {P_ROJO, P_AMAR, P_VERDE, P_TODAS, P_ILEGAL} pat_t;

  state_t        state;
  pat_t          pat;
  pat_t          run_pat;
  logic [CW-1:0] cnt;
  logic [CW-1:0] lim_lo;
  logic [CW-1:0] lim_hi;

  // Classify the sampled light pattern.
  always_comb begin
    pat = P_ILEGAL;
    case ({LUZ_ROJA, LUZ_AMARILLA, LUZ_VERDE})
      3'b100:  pat = P_ROJO;
      3'b010:  pat = P_AMAR;
      3'b001:  pat = P_VERDE;
      3'b111:  pat = P_TODAS;
      default: pat = P_ILEGAL;
    endcase
  end

  // Select run colour and legal length window for the run being tracked.
  always_comb begin
    run_pat = P_AMAR;
    lim_lo  = LENTO_LO;
    lim_hi  = LENTO_HI;
    if (state == M_RAPIDO) begin
      run_pat = P_VERDE;
      lim_lo  = RAPIDO_LO;
      lim_hi  = RAPIDO_HI;
    end
  end

  // Sequence checker FSM with registered outputs; error state is sticky until reset.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state    <= M_IDLE;
      cnt      <= '0;
      MODO     <= 2'b00;
      ACTIVO   <= 1'b0;
      DURACION <= '0;
      DONE     <= 1'b0;
      ERROR    <= 1'b0;
      ERR_CODE <= 3'd0;
    end else begin
      DONE <= 1'b0;
      case (state)
        M_IDLE: begin
          case (pat)
            P_ROJO: ;
            P_AMAR: begin
              state  <= M_LENTO;
              cnt    <= CW'(1);
              MODO   <= 2'b01;
              ACTIVO <= 1'b1;
            end
            P_VERDE: begin
              state  <= M_RAPIDO;
              cnt    <= CW'(1);
              MODO   <= 2'b10;
              ACTIVO <= 1'b1;
            end
            P_TODAS: begin
              state    <= M_ERROR;
              ERROR    <= 1'b1;
              ERR_CODE <= E_SALTO;
              ACTIVO   <= 1'b0;
            end
            default: begin
              state    <= M_ERROR;
              ERROR    <= 1'b1;
              ERR_CODE <= E_ILEGAL;
              ACTIVO   <= 1'b0;
            end
          endcase
        end
        M_LENTO, M_RAPIDO: begin
          if (pat == run_pat) begin
            // Run colour still present at the upper limit: too long, flag now.
            if (cnt >= lim_hi) begin
              state    <= M_ERROR;
              ERROR    <= 1'b1;
              ERR_CODE <= E_LARGO;
              ACTIVO   <= 1'b0;
            end else if (cnt != '1) begin
              cnt <= cnt + 1'b1;
            end
          end else if (pat == P_TODAS) begin
            DURACION <= cnt;
            if (cnt < lim_lo) begin
              state    <= M_ERROR;
              ERROR    <= 1'b1;
              ERR_CODE <= E_CORTO;
              ACTIVO   <= 1'b0;
            end else begin
              state  <= M_FINAL;
              DONE   <= 1'b1;
              ACTIVO <= 1'b0;
            end
          end else begin
            state    <= M_ERROR;
            ERROR    <= 1'b1;
            ERR_CODE <= E_ILEGAL;
            ACTIVO   <= 1'b0;
          end
        end
        M_FINAL: begin
          if (pat != P_TODAS) begin
            state    <= M_ERROR;
            ERROR    <= 1'b1;
            ERR_CODE <= E_POST;
            ACTIVO   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_luces_monitor.sv
// Directed-vector bench for luces_monitor: legal runs, length errors, ordering errors, async reset.
module tb_luces_monitor;

  localparam logic [2:0] ROJO   = 3'b100;
  localparam logic [2:0] AMAR   = 3'b010;
  localparam logic [2:0] VERDE  = 3'b001;
  localparam logic [2:0] TODAS  = 3'b111;
  localparam logic [2:0] P110   = 3'b110;
  localparam logic [2:0] P000   = 3'b000;
  localparam logic [2:0] P011   = 3'b011;

`ifdef LUCES_TOLERANCIA_EN
  localparam int N_LONG = 21 + 1 + 1;
`else
  localparam int N_LONG = 21 + 1;
`endif

  logic       CLK;
  logic       RESET;
  logic       LUZ_ROJA, LUZ_AMARILLA, LUZ_VERDE;
  logic [1:0] MODO;
  logic       ACTIVO;
  logic [5:0] DURACION;
  logic       DONE;
  logic       ERROR;
  logic [2:0] ERR_CODE;

  int n_checks;
  int n_fail;

  luces_monitor dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .LUZ_ROJA     (LUZ_ROJA),
    .LUZ_AMARILLA (LUZ_AMARILLA),
    .LUZ_VERDE    (LUZ_VERDE),
    .MODO         (MODO),
    .ACTIVO       (ACTIVO),
    .DURACION     (DURACION),
    .DONE         (DONE),
    .ERROR        (ERROR),
    .ERR_CODE     (ERR_CODE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Drive one pattern, let one rising edge sample it, then look 1 ns later.
  task automatic put(input logic [2:0] p);
    {LUZ_ROJA, LUZ_AMARILLA, LUZ_VERDE} = p;
    @(posedge CLK);
    #1;
  endtask

  task automatic put_n(input logic [2:0] p, input int n);
    for (int i = 0; i < n; i++) put(p);
  endtask

  // Pulse reset between clock edges with red showing.
  task automatic do_reset();
    @(negedge CLK);
    {LUZ_ROJA, LUZ_AMARILLA, LUZ_VERDE} = ROJO;
    RESET = 1'b1;
    #2;
    RESET = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    {LUZ_ROJA, LUZ_AMARILLA, LUZ_VERDE} = ROJO;
    #12;
    n_checks++;
    if ({MODO, ACTIVO, DURACION, DONE, ERROR, ERR_CODE} !== 14'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b want 0", {MODO, ACTIVO, DURACION, DONE, ERROR, ERR_CODE});
    end
    RESET = 1'b0;
  endtask

  task automatic test_slow_run();
    do_reset();
    put_n(ROJO, 5);
    n_checks++;
    if ({MODO, ACTIVO} !== 3'b000) begin
      n_fail++; $display("FAIL slow_idle: got %b want 000", {MODO, ACTIVO});
    end
    put(AMAR);
    n_checks++;
    if ({MODO, ACTIVO} !== 3'b011) begin
      n_fail++; $display("FAIL slow_start: got %b want 011", {MODO, ACTIVO});
    end
    put_n(AMAR, 20);
    n_checks++;
    if ({DONE, ERROR, ACTIVO} !== 3'b001) begin
      n_fail++; $display("FAIL slow_midrun: got %b want 001", {DONE, ERROR, ACTIVO});
    end
    put(TODAS);
    n_checks++;
    if ({DONE, ERROR, ACTIVO, MODO, DURACION} !== {3'b100, 2'b01, 6'd21}) begin
      n_fail++; $display("FAIL slow_done: got %b want %b", {DONE, ERROR, ACTIVO, MODO, DURACION}, {3'b100, 2'b01, 6'd21});
    end
    for (int i = 0; i < 9; i++) begin
      put(TODAS);
      n_checks++;
      if ({DONE, ERROR, MODO, DURACION} !== {2'b00, 2'b01, 6'd21}) begin
        n_fail++; $display("FAIL slow_hold[%0d]: got %b want %b", i, {DONE, ERROR, MODO, DURACION}, {2'b00, 2'b01, 6'd21});
      end
    end
  endtask

  task automatic test_fast_run();
    do_reset();
    put_n(ROJO, 3);
    put_n(VERDE, 11);
    n_checks++;
    if ({MODO, ACTIVO, DONE} !== 4'b1010) begin
      n_fail++; $display("FAIL fast_midrun: got %b want 1010", {MODO, ACTIVO, DONE});
    end
    put(TODAS);
    n_checks++;
    if ({DONE, ERROR, MODO, DURACION} !== {2'b10, 2'b10, 6'd11}) begin
      n_fail++; $display("FAIL fast_done: got %b want %b", {DONE, ERROR, MODO, DURACION}, {2'b10, 2'b10, 6'd11});
    end
    put(TODAS);
    n_checks++;
    if (DONE !== 1'b0) begin
      n_fail++; $display("FAIL fast_done_pulse: got %b want 0", DONE);
    end
  endtask

  task automatic test_short_run();
    do_reset();
    put_n(VERDE, 9);
    put(TODAS);
    n_checks++;
    if ({DONE, ERROR, ERR_CODE, DURACION} !== {2'b01, 3'd3, 6'd9}) begin
      n_fail++; $display("FAIL short_corto: got %b want %b", {DONE, ERROR, ERR_CODE, DURACION}, {2'b01, 3'd3, 6'd9});
    end
    do_reset();
    put_n(VERDE, 10);
    put(TODAS);
    n_checks++;
`ifdef LUCES_TOLERANCIA_EN
    if ({DONE, ERROR, ERR_CODE, DURACION} !== {2'b10, 3'd0, 6'd10}) begin
      n_fail++; $display("FAIL short_tol: got %b want %b", {DONE, ERROR, ERR_CODE, DURACION}, {2'b10, 3'd0, 6'd10});
    end
`else
    if ({DONE, ERROR, ERR_CODE, DURACION} !== {2'b01, 3'd3, 6'd10}) begin
      n_fail++; $display("FAIL short_exact: got %b want %b", {DONE, ERROR, ERR_CODE, DURACION}, {2'b01, 3'd3, 6'd10});
    end
`endif
  endtask

  task automatic test_long_run();
    do_reset();
    put_n(AMAR, N_LONG - 1);
    n_checks++;
    if ({ERROR, ACTIVO} !== 2'b01) begin
      n_fail++; $display("FAIL long_before: got %b want 01", {ERROR, ACTIVO});
    end
    put(AMAR);
    n_checks++;
    if ({ERROR, ERR_CODE, ACTIVO, DONE, MODO} !== {1'b1, 3'd4, 2'b00, 2'b01}) begin
      n_fail++; $display("FAIL long_largo: got %b want %b", {ERROR, ERR_CODE, ACTIVO, DONE, MODO}, {1'b1, 3'd4, 2'b00, 2'b01});
    end
  endtask

  task automatic test_order_errors();
    // Illegal pattern in idle, then further distinct errors.
    do_reset();
    put(P110);
    n_checks++;
    if ({ERROR, ERR_CODE} !== {1'b1, 3'd1}) begin
      n_fail++; $display("FAIL err_ilegal: got %b want %b", {ERROR, ERR_CODE}, {1'b1, 3'd1});
    end
    put(TODAS); put(P000); put(AMAR);
    n_checks++;
    if ({ERROR, ERR_CODE, DONE} !== {1'b1, 3'd1, 1'b0}) begin
      n_fail++; $display("FAIL err_ilegal_sticky: got %b want %b", {ERROR, ERR_CODE, DONE}, {1'b1, 3'd1, 1'b0});
    end
    // All lights straight from red.
    do_reset();
    put(ROJO);
    put(TODAS);
    n_checks++;
    if ({ERROR, ERR_CODE} !== {1'b1, 3'd2}) begin
      n_fail++; $display("FAIL err_salto: got %b want %b", {ERROR, ERR_CODE}, {1'b1, 3'd2});
    end
    put(P110); put(P000); put(VERDE);
    n_checks++;
    if ({ERROR, ERR_CODE, ACTIVO} !== {1'b1, 3'd2, 1'b0}) begin
      n_fail++; $display("FAIL err_salto_sticky: got %b want %b", {ERROR, ERR_CODE, ACTIVO}, {1'b1, 3'd2, 1'b0});
    end
    // Red after a completed run.
    do_reset();
    put_n(AMAR, 21);
    put(TODAS);
    put(ROJO);
    n_checks++;
    if ({ERROR, ERR_CODE, DONE, MODO} !== {1'b1, 3'd5, 1'b0, 2'b01}) begin
      n_fail++; $display("FAIL err_post: got %b want %b", {ERROR, ERR_CODE, DONE, MODO}, {1'b1, 3'd5, 1'b0, 2'b01});
    end
    put(P011); put(TODAS); put(P000);
    n_checks++;
    if ({ERROR, ERR_CODE} !== {1'b1, 3'd5}) begin
      n_fail++; $display("FAIL err_post_sticky: got %b want %b", {ERROR, ERR_CODE}, {1'b1, 3'd5});
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    put_n(AMAR, 7);
    n_checks++;
    if ({MODO, ACTIVO} !== 3'b011) begin
      n_fail++; $display("FAIL async_prerun: got %b want 011", {MODO, ACTIVO});
    end
    @(negedge CLK);
    RESET = 1'b1;
    #1;
    n_checks++;
    if ({MODO, ACTIVO, DURACION, DONE, ERROR, ERR_CODE} !== 14'd0) begin
      n_fail++; $display("FAIL async_clear: got %b want 0", {MODO, ACTIVO, DURACION, DONE, ERROR, ERR_CODE});
    end
    {LUZ_ROJA, LUZ_AMARILLA, LUZ_VERDE} = ROJO;
    #1;
    RESET = 1'b0;
    put_n(ROJO, 3);
    put_n(VERDE, 11);
    put(TODAS);
    n_checks++;
    if ({DONE, ERROR, MODO, DURACION} !== {2'b10, 2'b10, 6'd11}) begin
      n_fail++; $display("FAIL async_fast_done: got %b want %b", {DONE, ERROR, MODO, DURACION}, {2'b10, 2'b10, 6'd11});
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_slow_run();
    test_fast_run();
    test_short_run();
    test_long_run();
    test_order_errors();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
